// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the blinker-board LFSR: seed loading, step pacing,
// all-zero lock-up recovery and a valid/ready seed port.
module lfsr_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned CNT_W = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_ready,
  input  logic [WIDTH-1:0] lfsr_out,
  output logic             lfsr_rst,
  output logic             lfsr_enb,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             running,
  output logic             lockup,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             seed_xfer;

  // Strobes come from registered state only; lockup also looks at inputs
  // so it stays quiet whenever a higher-priority event wins the cycle.
  assign running    = (state_q == RUN);
  assign lfsr_rst   = (state_q == LOAD);
  assign seed_ready = (state_q != LOAD);
  assign lfsr_enb   = running && (presc_q == div_q - DIV_W'(1));
  assign lfsr_seed  = seed_q;
  assign step_cnt   = step_q;
  assign seed_xfer  = seed_valid && seed_ready;
  assign lockup     = running && (lfsr_out == '0) && !stop
                      && !start && !seed_xfer;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    step_d  = step_q;
    seed_d  = seed_q;
    if (seed_xfer) begin
      seed_d = (seed_data == '0) ? DEFAULT_SEED : seed_data;
    end
    unique case (state_q)
      IDLE: begin
        if (start && !stop) state_d = LOAD;
      end
      LOAD: begin
        presc_d = '0;
        step_d  = '0;
        div_d   = (div == '0) ? DIV_W'(1) : div;
        state_d = stop ? IDLE : RUN;
      end
      RUN: begin
        if (lfsr_enb) begin
          presc_d = '0;
          step_d  = step_q + CNT_W'(1);
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
        if (stop) begin
          state_d = IDLE;
        end else if (start || seed_xfer) begin
          state_d = LOAD;
        end else if (lfsr_out == '0) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      div_q   <= DIV_W'(1);
      step_q  <= '0;
      seed_q  <= DEFAULT_SEED;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      step_q  <= step_d;
      seed_q  <= seed_d;
    end
  end

endmodule
